// File: rtl/dec_issue_stage_if.sv
// Execute-side bus of the decode/issue stage: registered instruction fields
// plus the valid/ready handshake toward execute.
interface dec_issue_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              out_valid_q_o;
  logic              out_ready_i;
  logic [XLEN-1:0]   pc_q_o;
  logic [XLEN-1:0]   imm_q_o;
  logic              rd_v_q_o;
  logic [4:0]        rd_adr_q_o;
  logic [XLEN:0]     rs1_data_q_o;
  logic [XLEN:0]     rs2_data_q_o;
  logic [CTRL_W-1:0] ctrl_q_o;

  modport master (
    output out_valid_q_o, pc_q_o, imm_q_o, rd_v_q_o, rd_adr_q_o,
           rs1_data_q_o, rs2_data_q_o, ctrl_q_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_q_o, pc_q_o, imm_q_o, rd_v_q_o, rd_adr_q_o,
           rs1_data_q_o, rs2_data_q_o, ctrl_q_o,
    output out_ready_i
  );
endinterface

// File: rtl/dec_issue_stage.sv
// Decode/issue stage: operand forwarding, load scoreboard, qualified
// (XLEN+1 bit) operands and a registered valid/ready output toward execute.
module dec_issue_stage #(
  parameter int XLEN   = 32,
  parameter int NB_FF  = 2,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [XLEN-1:0]             pc_i,
  input  logic                        rs1_v_i,
  input  logic                        rs2_v_i,
  input  logic [4:0]                  rs1_adr_i,
  input  logic [4:0]                  rs2_adr_i,
  input  logic                        rd_v_i,
  input  logic [4:0]                  rd_adr_i,
  input  logic                        rd_late_i,
  input  logic [XLEN-1:0]             imm_i,
  input  logic                        rs1_is_imm_i,
  input  logic                        rs2_is_imm_i,
  input  logic                        auipc_i,
  input  logic                        rs2_neg_i,
  input  logic                        unsign_i,
  input  logic [CTRL_W-1:0]           ctrl_i,
  output logic [4:0]                  rf_rs1_adr_o,
  output logic [4:0]                  rf_rs2_adr_o,
  input  logic [XLEN-1:0]             rf_rs1_data_i,
  input  logic [XLEN-1:0]             rf_rs2_data_i,
  input  logic [NB_FF-1:0]            ff_v_i,
  input  logic [NB_FF-1:0][4:0]       ff_adr_i,
  input  logic [NB_FF-1:0][XLEN-1:0]  ff_data_i,
  input  logic                        wbk_v_i,
  input  logic [4:0]                  wbk_adr_i,
  input  logic [XLEN-1:0]             wbk_data_i,
  input  logic                        flush_v_i,
  dec_issue_stage_if.master           ex,
  output logic [CNT_W-1:0]            stall_cnt_q_o
);

  logic [31:0]       pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              late_q;
  logic [XLEN-1:0]   pc_q, imm_q;
  logic              rd_v_q;
  logic [4:0]        rd_adr_q;
  logic [XLEN:0]     op1_q, op2_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic [1:0][4:0]      src_adr;
  logic [1:0][XLEN-1:0] src_rf, src_val;
  logic [1:0]           src_used, src_haz;
  logic                 hazard, accept, sets_pend;
  logic [XLEN-1:0]      op1_raw, op2_raw;
  logic [XLEN:0]        op1, op2_ext, op2;

  assign rf_rs1_adr_o = rs1_adr_i;
  assign rf_rs2_adr_o = rs2_adr_i;

  // Per-source value: x0, then lowest-index forward port, then writeback, then RF
  always_comb begin
    src_adr  = {rs2_adr_i, rs1_adr_i};
    src_rf   = {rf_rs2_data_i, rf_rs1_data_i};
    src_used = {rs2_v_i & ~rs2_is_imm_i, rs1_v_i & ~rs1_is_imm_i};
    for (int s = 0; s < 2; s++) begin
      src_val[s] = src_rf[s];
      if (wbk_v_i && wbk_adr_i == src_adr[s]) src_val[s] = wbk_data_i;
      for (int k = NB_FF-1; k >= 0; k--)
        if (ff_v_i[k] && ff_adr_i[k] == src_adr[s]) src_val[s] = ff_data_i[k];
      if (src_adr[s] == 5'd0) src_val[s] = '0;
      src_haz[s] = src_used[s] && (src_adr[s] != 5'd0) && pend_q[src_adr[s]] &&
                   !(wbk_v_i && wbk_adr_i == src_adr[s]);
    end
  end

  always_comb begin
    op1_raw = rs1_is_imm_i ? imm_i : auipc_i ? pc_i : rs1_v_i ? src_val[0] : '0;
    op2_raw = rs2_is_imm_i ? imm_i : rs2_v_i ? src_val[1] : '0;
    op1     = {~unsign_i & op1_raw[XLEN-1], op1_raw};
    op2_ext = {~unsign_i & op2_raw[XLEN-1], op2_raw};
    op2     = rs2_neg_i ? (~op2_ext + {{XLEN{1'b0}}, 1'b1}) : op2_ext;
  end

  assign hazard     = |src_haz;
  assign in_ready_o = (~vld_q | ex.out_ready_i) & ~hazard & ~flush_v_i;
  assign accept     = in_valid_i & in_ready_o;
  assign sets_pend  = rd_v_i & rd_late_i & (rd_adr_i != 5'd0);

  always_comb begin
    pend_d = pend_q;
    if (wbk_v_i) pend_d[wbk_adr_i] = 1'b0;
    // A flushed load never reaches writeback, so release its register here
    if (flush_v_i && vld_q && late_q) pend_d[rd_adr_q] = 1'b0;
    if (accept && sets_pend) pend_d[rd_adr_i] = 1'b1;
    pend_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (in_valid_i && hazard && !flush_v_i && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;

    vld_d = vld_q;
    if (accept) vld_d = 1'b1;
    else if (flush_v_i || ex.out_ready_i) vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      late_q   <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      rd_v_q   <= 1'b0;
      rd_adr_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      if (accept) begin
        late_q   <= sets_pend;
        pc_q     <= pc_i;
        imm_q    <= imm_i;
        rd_v_q   <= rd_v_i;
        rd_adr_q <= rd_adr_i;
        op1_q    <= op1;
        op2_q    <= op2;
        ctrl_q   <= ctrl_i;
      end
    end
  end

  assign ex.out_valid_q_o = vld_q;
  assign ex.pc_q_o        = pc_q;
  assign ex.imm_q_o       = imm_q;
  assign ex.rd_v_q_o      = rd_v_q;
  assign ex.rd_adr_q_o    = rd_adr_q;
  assign ex.rs1_data_q_o  = op1_q;
  assign ex.rs2_data_q_o  = op2_q;
  assign ex.ctrl_q_o      = ctrl_q;
  assign stall_cnt_q_o    = cnt_q;

endmodule

// File: tb/tb_dec_issue_stage.sv
// Directed bench for dec_issue_stage: vector table for operand selection and
// forwarding, plus hand-written load-use, backpressure, flush and reset runs.
module tb_dec_issue_stage;
  localparam int XLEN = 32, NB_FF = 2, CTRL_W = 16, CNT_W = 4;

  logic clk = 1'b0, reset;
  always #5 clk = ~clk;

  logic in_valid, in_ready;
  logic [31:0] pc, imm, rf1, rf2, wbk_data;
  logic rs1_v, rs2_v, rd_v, rd_late, rs1_imm, rs2_imm, auipc, neg, uns;
  logic [4:0] rs1_adr, rs2_adr, rd_adr, rf1_adr, rf2_adr, wbk_adr;
  logic [15:0] ctrl;
  logic [1:0] ff_v;
  logic [1:0][4:0] ff_adr;
  logic [1:0][31:0] ff_data;
  logic wbk_v, flush;
  logic [CNT_W-1:0] stall_cnt;

  dec_issue_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) ex_if ();

  dec_issue_stage #(.XLEN(XLEN), .NB_FF(NB_FF), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc), .rs1_v_i(rs1_v), .rs2_v_i(rs2_v), .rs1_adr_i(rs1_adr), .rs2_adr_i(rs2_adr),
    .rd_v_i(rd_v), .rd_adr_i(rd_adr), .rd_late_i(rd_late), .imm_i(imm),
    .rs1_is_imm_i(rs1_imm), .rs2_is_imm_i(rs2_imm), .auipc_i(auipc), .rs2_neg_i(neg),
    .unsign_i(uns), .ctrl_i(ctrl), .rf_rs1_adr_o(rf1_adr), .rf_rs2_adr_o(rf2_adr),
    .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .ff_v_i(ff_v), .ff_adr_i(ff_adr),
    .ff_data_i(ff_data), .wbk_v_i(wbk_v), .wbk_adr_i(wbk_adr), .wbk_data_i(wbk_data),
    .flush_v_i(flush), .ex(ex_if), .stall_cnt_q_o(stall_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; pc = 0; imm = 0; rf1 = 0; rf2 = 0; rs1_v = 0; rs2_v = 0;
    rs1_adr = 0; rs2_adr = 0; rd_v = 0; rd_adr = 0; rd_late = 0; rs1_imm = 0;
    rs2_imm = 0; auipc = 0; neg = 0; uns = 0; ctrl = 0; ff_v = 0; ff_adr = '0;
    ff_data = '0; wbk_v = 0; wbk_adr = 0; wbk_data = 0; flush = 0;
  endtask

  typedef struct {
    logic [31:0] pc, imm, rf1, rf2;
    logic [4:0]  a1, a2;
    logic        v1, v2, i1, i2, au, ng, us;
    logic [1:0]  ffv;
    logic [4:0]  ffa0, ffa1;
    logic [31:0] ffd0, ffd1;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [32:0] e1, e2;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{default:0, pc:32'h0,  a1:1, v1:1, a2:2, v2:1, rf1:5, rf2:7, e1:33'h5, e2:33'h7};
    vecs[1] = '{default:0, pc:32'h4,  a1:1, v1:1, rf1:32'hFFFFFFFF, i2:1, imm:32'h10,
                e1:33'h1FFFFFFFF, e2:33'h10};
    vecs[2] = '{default:0, pc:32'h8,  a1:5, v1:1, a2:6, v2:1, rf1:32'h33, rf2:32'h77,
                ffv:2'b11, ffa0:5, ffd0:32'h11, ffa1:5, ffd1:32'h22, wv:1, wa:6, wd:32'h44,
                e1:33'h11, e2:33'h44};
    vecs[3] = '{default:0, pc:32'hC,  a1:0, v1:1, a2:9, v2:1, rf1:32'h55, rf2:32'h77,
                ffv:2'b11, ffa0:0, ffd0:32'hFF, ffa1:9, ffd1:32'h66, e1:33'h0, e2:33'h66};
    vecs[4] = '{default:0, pc:32'h10, a2:3, v2:1, rf2:32'h1, ng:1, e1:33'h0, e2:33'h1FFFFFFFF};
    vecs[5] = '{default:0, pc:32'h14, us:1, a1:4, v1:1, a2:4, v2:1, rf1:32'h80000000,
                rf2:32'h80000000, e1:33'h080000000, e2:33'h080000000};
    vecs[6] = '{default:0, pc:32'h18, au:1, a1:1, v1:1, rf1:32'h77, a2:2, rf2:32'h99,
                e1:33'h18, e2:33'h0};
    vecs[7] = '{default:0, pc:32'h1C, i1:1, imm:32'hFFFFFFF0, ng:1, e1:33'h1FFFFFFF0, e2:33'h0};
    vecs[8] = '{default:0, pc:32'h20, a2:3, v2:1, rf2:32'h80000000, ng:1,
                e1:33'h0, e2:33'h080000000};
    vecs[9] = '{default:0, pc:32'h24, a1:1, v1:1, a2:2, v2:1, ffv:2'b10, ffa0:1,
                ffd0:32'hBEEF, ffa1:1, ffd1:32'hDEAD, wv:1, wa:2, wd:32'h1234,
                e1:33'hDEAD, e2:33'h1234};

    idle();
    ex_if.out_ready_i = 1;
    reset = 1;
    step(); step();
    chk("rst_valid", 64'(ex_if.out_valid_q_o), 0);
    chk("rst_pc", 64'(ex_if.pc_q_o), 0);
    chk("rst_rs1", 64'(ex_if.rs1_data_q_o), 0);
    chk("rst_cnt", 64'(stall_cnt), 0);
    reset = 0;
    step();

    // Back-to-back table: one accept per cycle, valid stays high
    for (int i = 0; i < 10; i++) begin
      idle();
      in_valid = 1; pc = vecs[i].pc; imm = vecs[i].imm; rf1 = vecs[i].rf1; rf2 = vecs[i].rf2;
      rs1_adr = vecs[i].a1; rs2_adr = vecs[i].a2; rs1_v = vecs[i].v1; rs2_v = vecs[i].v2;
      rs1_imm = vecs[i].i1; rs2_imm = vecs[i].i2; auipc = vecs[i].au; neg = vecs[i].ng;
      uns = vecs[i].us; ff_v = vecs[i].ffv; ff_adr[0] = vecs[i].ffa0; ff_adr[1] = vecs[i].ffa1;
      ff_data[0] = vecs[i].ffd0; ff_data[1] = vecs[i].ffd1; wbk_v = vecs[i].wv;
      wbk_adr = vecs[i].wa; wbk_data = vecs[i].wd; rd_v = 1; rd_adr = 5'(i + 1);
      ctrl = 16'(i * 3 + 1);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(in_ready), 1);
      chk($sformatf("v%0d_rfadr", i), 64'({rf2_adr, rf1_adr}), 64'({vecs[i].a2, vecs[i].a1}));
      step();
      chk($sformatf("v%0d_valid", i), 64'(ex_if.out_valid_q_o), 1);
      chk($sformatf("v%0d_pc", i), 64'(ex_if.pc_q_o), 64'(vecs[i].pc));
      chk($sformatf("v%0d_rs1", i), 64'(ex_if.rs1_data_q_o), 64'(vecs[i].e1));
      chk($sformatf("v%0d_rs2", i), 64'(ex_if.rs2_data_q_o), 64'(vecs[i].e2));
      chk($sformatf("v%0d_rd", i), 64'(ex_if.rd_adr_q_o), 64'(i + 1));
      chk($sformatf("v%0d_ctrl", i), 64'(ex_if.ctrl_q_o), 64'(i * 3 + 1));
    end

    // Load-use stall on x7, released by writeback of x7
    idle();
    in_valid = 1; pc = 32'h200; rd_v = 1; rd_adr = 7; rd_late = 1;
    #1 chk("ld_ready", 64'(in_ready), 1);
    step();
    idle();
    in_valid = 1; pc = 32'h204; rs1_v = 1; rs1_adr = 7; rf1 = 32'h1234; rd_v = 1; rd_adr = 8;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("lu_ready%0d", i), 64'(in_ready), 0);
      step();
      chk($sformatf("lu_cnt%0d", i), 64'(stall_cnt), 64'(i + 1));
    end
    wbk_v = 1; wbk_adr = 7; wbk_data = 32'hABCD;
    #1 chk("lu_wbk_ready", 64'(in_ready), 1);
    step();
    chk("lu_rs1", 64'(ex_if.rs1_data_q_o), 64'h0ABCD);
    chk("lu_pc", 64'(ex_if.pc_q_o), 64'h204);
    chk("lu_cnt_hold", 64'(stall_cnt), 3);
    wbk_v = 0; pc = 32'h208;
    #1 chk("lu_cleared", 64'(in_ready), 1);
    step();

    // Backpressure: output held for 3 cycles
    idle();
    step();
    ex_if.out_ready_i = 0;
    in_valid = 1; pc = 32'h300; rd_v = 1; rd_adr = 3;
    #1 chk("bp_first_ready", 64'(in_ready), 1);
    step();
    pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp_ready%0d", i), 64'(in_ready), 0);
      step();
      chk($sformatf("bp_valid%0d", i), 64'(ex_if.out_valid_q_o), 1);
      chk($sformatf("bp_pc%0d", i), 64'(ex_if.pc_q_o), 64'h300);
    end
    ex_if.out_ready_i = 1;
    #1 chk("bp_release", 64'(in_ready), 1);
    step();
    chk("bp_next_pc", 64'(ex_if.pc_q_o), 64'h304);

    // Flush of a held load releases only its own pending bit
    idle();
    in_valid = 1; pc = 32'h400; rd_v = 1; rd_adr = 10; rd_late = 1;
    step();
    pc = 32'h404; rd_adr = 9;
    step();
    idle();
    ex_if.out_ready_i = 0; flush = 1;
    in_valid = 1; pc = 32'h408; rs1_v = 1; rs1_adr = 9;
    #1 chk("fl_ready", 64'(in_ready), 0);
    step();
    chk("fl_valid", 64'(ex_if.out_valid_q_o), 0);
    flush = 0;
    #1 chk("fl_x9_free", 64'(in_ready), 1);
    rs1_adr = 10;
    #1 chk("fl_x10_pend", 64'(in_ready), 0);
    wbk_v = 1; wbk_adr = 10; wbk_data = 32'h5;
    ex_if.out_ready_i = 1;
    step();
    chk("fl_x10_fwd", 64'(ex_if.rs1_data_q_o), 64'h5);

    // Counter saturation, then reset in the middle of the stall
    idle();
    reset = 1; step(); reset = 0;
    chk("sat_cnt0", 64'(stall_cnt), 0);
    in_valid = 1; pc = 32'h500; imm = 32'h77; rd_v = 1; rd_adr = 11; rd_late = 1; ctrl = 16'h5A;
    step();
    rd_late = 0; rd_adr = 12; pc = 32'h504; rs1_v = 1; rs1_adr = 11;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", 64'(stall_cnt), 15);
    chk("sat_ready", 64'(in_ready), 0);
    reset = 1;
    step();
    chk("rst2_valid", 64'(ex_if.out_valid_q_o), 0);
    chk("rst2_pc", 64'(ex_if.pc_q_o), 0);
    chk("rst2_imm", 64'(ex_if.imm_q_o), 0);
    chk("rst2_rd", 64'({ex_if.rd_v_q_o, ex_if.rd_adr_q_o}), 0);
    chk("rst2_ops", 64'(ex_if.rs1_data_q_o | ex_if.rs2_data_q_o), 0);
    chk("rst2_ctrl", 64'(ex_if.ctrl_q_o), 0);
    chk("rst2_cnt", 64'(stall_cnt), 0);
    reset = 0;
    #1 chk("rst2_pend_clr", 64'(in_ready), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
